// File: rtl/counter_scheduler.sv
// Round-robin scheduler sharing one loadable up-counter as a delay timer among NREQ requesters.
// Optional abort-on-request-drop behaviour is enabled by defining CNT_SCHED_ABORT_EN.
module counter_scheduler #(
    parameter int WIDTH = 3,
    parameter int NREQ  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*WIDTH-1:0] i_dly,
    output logic [NREQ-1:0]       o_grant,
    output logic [NREQ-1:0]       o_done,
    output logic                  o_busy,
    output logic                  o_cnt_load,
    output logic                  o_cnt_en,
    output logic [WIDTH-1:0]      o_cnt_in,
    input  logic                  i_cnt_co
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    logic [1:0]       r_state;
    logic [IW-1:0]    r_owner;
    logic [IW-1:0]    r_last;
    logic [WIDTH-1:0] r_code;

    logic             w_found;
    logic [IW-1:0]    w_win;
    logic [IW-1:0]    w_idx;
    logic [WIDTH-1:0] w_code;
    logic [NREQ-1:0]  w_own_oh;

    // Search begins one past the last owner, so the previous owner is tried last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = IW'((32'(r_last) + k) % NREQ);
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_code = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_win == IW'(i)) begin
                w_code = i_dly[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_own_oh = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_own_oh[i] = (r_owner == IW'(i));
        end
    end

`ifdef CNT_SCHED_ABORT_EN
    logic w_own_req;
    assign w_own_req = |(i_req & w_own_oh);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_code  <= '0;
            r_last  <= LAST_RST;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_win;
                        r_code  <= w_code;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
`ifdef CNT_SCHED_ABORT_EN
                    if (!w_own_req) begin
                        r_state <= S_IDLE;
                        r_last  <= r_owner;
                    end else begin
                        r_state <= S_RUN;
                    end
`else
                    r_state <= S_RUN;
`endif
                end
                S_RUN: begin
`ifdef CNT_SCHED_ABORT_EN
                    if (!w_own_req) begin
                        r_state <= S_IDLE;
                        r_last  <= r_owner;
                    end else if (i_cnt_co) begin
                        r_state <= S_DONE;
                    end
`else
                    if (i_cnt_co) begin
                        r_state <= S_DONE;
                    end
`endif
                end
                S_DONE: begin
                    r_last  <= r_owner;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Loading the inverted code leaves exactly code increments to all-ones.
    always_comb begin
        o_busy     = (r_state != S_IDLE);
        o_grant    = o_busy ? w_own_oh : '0;
        o_done     = (r_state == S_DONE) ? w_own_oh : '0;
        o_cnt_load = (r_state == S_LOAD);
        o_cnt_en   = (r_state == S_RUN);
        o_cnt_in   = (r_state == S_LOAD) ? ~r_code : '0;
    end

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed self-checking bench for counter_scheduler; models the external loadable counter.
// Abort checks follow CNT_SCHED_ABORT_EN when defined.
module tb_counter_scheduler;
    localparam int WIDTH = 3;
    localparam int NREQ  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] dly;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  cnt_load;
    logic                  cnt_en;
    logic [WIDTH-1:0]      cnt_in;
    logic                  cnt_co;
    logic [WIDTH-1:0]      cnt = '0;

    int n_tests = 0;
    int n_fail  = 0;

    counter_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_dly      (dly),
        .o_grant    (grant),
        .o_done     (done),
        .o_busy     (busy),
        .o_cnt_load (cnt_load),
        .o_cnt_en   (cnt_en),
        .o_cnt_in   (cnt_in),
        .i_cnt_co   (cnt_co)
    );

    always #5 clk = ~clk;

    // Reference model of the shared counter: load has priority, co is combinational.
    always @(posedge clk) begin
        if (cnt_load) cnt <= cnt_in;
        else if (cnt_en) cnt <= cnt + 1'b1;
    end
    assign cnt_co = (cnt == 3'b111) && cnt_en;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; req = '0; dly = '0;
        tick; tick;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL reset_done: got %b expected 0000", done); end
        n_tests++; if ({cnt_load, cnt_en} !== 2'b00) begin n_fail++; $display("FAIL reset_ctl: got %b expected 00", {cnt_load, cnt_en}); end
        n_tests++; if (cnt_in !== 3'b000) begin n_fail++; $display("FAIL reset_cnt_in: got %b expected 000", cnt_in); end
        rst = 1'b0;
        tick;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single;
        dly = '0; dly[2:0] = 3'd2; req = 4'b0001;
        tick;
        n_tests++; if (cnt_load !== 1'b1 || cnt_en !== 1'b0) begin n_fail++; $display("FAIL single_load: got load=%b en=%b expected load=1 en=0", cnt_load, cnt_en); end
        n_tests++; if (cnt_in !== 3'b101) begin n_fail++; $display("FAIL single_cnt_in: got %b expected 101", cnt_in); end
        n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b expected 0001", grant); end
        for (int c = 1; c <= 3; c++) begin
            tick;
            n_tests++; if (cnt_en !== 1'b1 || cnt_load !== 1'b0 || cnt_in !== 3'b000) begin n_fail++; $display("FAIL single_run c%0d: got en=%b load=%b in=%b expected en=1 load=0 in=000", c, cnt_en, cnt_load, cnt_in); end
            n_tests++; if (cnt_co !== (c == 3)) begin n_fail++; $display("FAIL single_co c%0d: got %b expected %b", c, cnt_co, (c == 3)); end
        end
        tick;
        n_tests++; if (done !== 4'b0001 || cnt_en !== 1'b0) begin n_fail++; $display("FAIL single_done: got done=%b en=%b expected done=0001 en=0", done, cnt_en); end
        req = '0;
        tick;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_extremes;
        logic [2:0] code;
        int d;
        for (int t = 0; t < 2; t++) begin
            code = (t == 0) ? 3'd0 : 3'd7;
            d = int'(code) + 1;
            dly = '0; dly[2:0] = code; req = 4'b0001;
            tick;
            n_tests++; if (cnt_in !== ~code || cnt_load !== 1'b1) begin n_fail++; $display("FAIL extreme_load code%0d: got in=%b load=%b expected in=%b load=1", code, cnt_in, cnt_load, ~code); end
            for (int c = 1; c <= d; c++) begin
                tick;
                n_tests++; if (cnt_en !== 1'b1 || cnt_co !== (c == d)) begin n_fail++; $display("FAIL extreme_run code%0d c%0d: got en=%b co=%b expected en=1 co=%b", code, c, cnt_en, cnt_co, (c == d)); end
                n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL extreme_early_done code%0d c%0d: got %b expected 0000", code, c, done); end
            end
            tick;
            n_tests++; if (done !== 4'b0001) begin n_fail++; $display("FAIL extreme_done code%0d: got %b expected 0001", code, done); end
            req = '0;
            tick;
            n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL extreme_idle code%0d: got busy=%b expected 0", code, busy); end
        end
    endtask

    task automatic test_fairness;
        logic [3:0] exp;
        rst = 1'b1; tick;
        rst = 1'b0; req = 4'b1111; dly = '0;
        for (int c = 0; c < 20; c++) begin
            tick;
            exp = 4'b0001 << ((c / 4) % 4);
            if (c % 4 == 0) begin
                n_tests++; if (grant !== exp || cnt_load !== 1'b1) begin n_fail++; $display("FAIL fair_grant c%0d: got grant=%b load=%b expected grant=%b load=1", c, grant, cnt_load, exp); end
            end
            if (c % 4 == 2) begin
                n_tests++; if (done !== exp) begin n_fail++; $display("FAIL fair_done c%0d: got %b expected %b", c, done, exp); end
            end
            n_tests++; if ((done & ~grant) !== 4'b0000) begin n_fail++; $display("FAIL fair_nonowner_done c%0d: got done=%b grant=%b expected no stray done", c, done, grant); end
            n_tests++; if ((cnt_load & cnt_en) !== 1'b0) begin n_fail++; $display("FAIL fair_load_en c%0d: got load=%b en=%b expected not both", c, cnt_load, cnt_en); end
            if (c == 18) req = '0;
        end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fair_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_late_arrival;
        dly = '0; dly[5:3] = 3'd3; req = 4'b0010;
        tick;
        n_tests++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL late_grant1: got %b expected 0010", grant); end
        for (int c = 1; c <= 15; c++) begin
            tick;
            if (c == 2) begin req[2] = 1'b1; dly[8:6] = 3'd1; end
            if (c == 4) dly[8:6] = 3'd5;
            if (c == 5) begin
                n_tests++; if (done !== 4'b0010) begin n_fail++; $display("FAIL late_done1: got %b expected 0010", done); end
                req[1] = 1'b0;
            end
            if (c == 6) begin
                n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL late_gap: got busy=%b expected 0", busy); end
            end
            if (c == 7) begin
                n_tests++; if (grant !== 4'b0100 || cnt_in !== 3'b010) begin n_fail++; $display("FAIL late_grant2: got grant=%b in=%b expected grant=0100 in=010", grant, cnt_in); end
                dly[8:6] = 3'd0;
            end
            if (c == 13) begin
                n_tests++; if (cnt_co !== 1'b1 || done !== 4'b0000) begin n_fail++; $display("FAIL late_co: got co=%b done=%b expected co=1 done=0000", cnt_co, done); end
            end
            if (c == 14) begin
                n_tests++; if (done !== 4'b0100) begin n_fail++; $display("FAIL late_done2: got %b expected 0100", done); end
                req = '0;
            end
        end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL late_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid_run;
        dly = '0; dly[2:0] = 3'd5; req = 4'b0001;
        tick; tick; tick;
        n_tests++; if (cnt_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_run: got en=%b expected 1", cnt_en); end
        rst = 1'b1;
        tick;
        n_tests++; if (busy !== 1'b0 || grant !== 4'b0000 || cnt_en !== 1'b0 || done !== 4'b0000) begin n_fail++; $display("FAIL rstmid_clear: got busy=%b grant=%b en=%b done=%b expected all 0", busy, grant, cnt_en, done); end
        rst = 1'b0; req = 4'b1010; dly = '0;
        tick;
        n_tests++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL rstmid_priority: got %b expected 0010", grant); end
        tick;
        tick;
        n_tests++; if (done !== 4'b0010) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0010", done); end
        req = '0;
        tick; tick;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_abort;
        dly = '0; dly[2:0] = 3'd5; req = 4'b0001;
        tick; tick;
        n_tests++; if (cnt_en !== 1'b1) begin n_fail++; $display("FAIL abort_run: got en=%b expected 1", cnt_en); end
        req = '0;
        for (int c = 2; c <= 8; c++) begin
            tick;
`ifdef CNT_SCHED_ABORT_EN
            n_tests++; if (cnt_en !== 1'b0 || done !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_drop c%0d: got en=%b done=%b busy=%b expected all 0", c, cnt_en, done, busy); end
`else
            n_tests++; if (cnt_en !== (c <= 6)) begin n_fail++; $display("FAIL abort_en c%0d: got %b expected %b", c, cnt_en, (c <= 6)); end
            n_tests++; if (done !== ((c == 7) ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL abort_done c%0d: got %b expected %b", c, done, ((c == 7) ? 4'b0001 : 4'b0000)); end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; dly = '0;
        @(negedge clk);
        test_reset;
        test_single;
        test_extremes;
        test_fairness;
        test_late_arrival;
        test_reset_mid_run;
        test_abort;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
